// File: rtl/dmem_copy_pkg.sv
// rtl/dmem_copy_pkg.sv - shared state encoding and default widths for the data-memory copy engine
package dmem_copy_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LEN_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_copy_addr_gen.sv
// rtl/dmem_copy_addr_gen.sv - copy direction decision, source/destination pointers and remaining-word counter
module dmem_copy_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic [LEN_W-1:0]  remaining,
  output logic              last
);

  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              desc_q, desc_d;

  logic [ADDR_W-1:0] len_a;
  logic [ADDR_W-1:0] len_m1;
  logic [ADDR_W:0]   src_ext, dst_ext, src_end;
  logic              desc_load;

  // Overlap test is done one bit wider so src+length never wraps; a destination
  // strictly inside the source window must be copied from the top down.
  always_comb begin
    len_a     = {{(ADDR_W-LEN_W){1'b0}}, length};
    len_m1    = len_a - ADDR_W'(1);
    src_ext   = {1'b0, src_addr};
    dst_ext   = {1'b0, dst_addr};
    src_end   = src_ext + {1'b0, len_a};
    desc_load = (dst_ext > src_ext) && (dst_ext < src_end);
  end

  // Load pointers on start accept, step them once per committed write.
  always_comb begin
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    desc_d      = desc_q;
    if (load) begin
      desc_d      = desc_load;
      src_ptr_d   = desc_load ? (src_addr + len_m1) : src_addr;
      dst_ptr_d   = desc_load ? (dst_addr + len_m1) : dst_addr;
      remaining_d = length;
    end else if (step) begin
      src_ptr_d   = desc_q ? (src_ptr_q - ADDR_W'(1)) : (src_ptr_q + ADDR_W'(1));
      dst_ptr_d   = desc_q ? (dst_ptr_q - ADDR_W'(1)) : (dst_ptr_q + ADDR_W'(1));
      remaining_d = remaining_q - LEN_W'(1);
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      desc_q      <= 1'b0;
    end else begin
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      desc_q      <= desc_d;
    end
  end

  assign src_ptr   = src_ptr_q;
  assign dst_ptr   = dst_ptr_q;
  assign remaining = remaining_q;
  assign last      = (remaining_q == LEN_W'(1));

endmodule

// File: rtl/dmem_copy_engine.sv
// rtl/dmem_copy_engine.sv - word copy engine on the data-memory port; optional checksum via DMEM_COPY_CHECKSUM_EN
module dmem_copy_engine
  import dmem_copy_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [LEN_W-1:0]  words_done_q, words_done_d;

  logic              load, step, last;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [LEN_W-1:0]  remaining;

  assign load = (state_q == ST_IDLE) && start;
  assign step = (state_q == ST_WRITE);

  dmem_copy_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .src_ptr   (src_ptr),
    .dst_ptr   (dst_ptr),
    .remaining (remaining),
    .last      (last)
  );

  // Next state and memory-port drive; the port is decoded from registered state
  // only, so mem_write falls the moment reset forces IDLE.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    words_done_d = words_done_q;
    busy         = 1'b0;
    done         = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          words_done_d = '0;
          state_d      = (length != '0) ? ST_READ : ST_DONE;
        end
      end
      ST_READ: begin
        busy     = 1'b1;
        mem_addr = src_ptr;
        hold_d   = mem_rdata;
        state_d  = abort ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        busy         = 1'b1;
        mem_addr     = dst_ptr;
        mem_wdata    = hold_q;
        mem_write    = 1'b1;
        words_done_d = words_done_q + LEN_W'(1);
        if (abort)     state_d = ST_IDLE;
        else if (last) state_d = ST_DONE;
        else           state_d = ST_READ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, read-hold register and completed-word counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      words_done_q <= words_done_d;
    end
  end

  assign words_done = words_done_q;

`ifdef DMEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running modular sum of every word read; restarts when a transfer is accepted.
  always_comb begin
    checksum_d = checksum_q;
    if (load)                       checksum_d = '0;
    else if (state_q == ST_READ)    checksum_d = checksum_q + mem_rdata;
  end

  // Checksum register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) checksum_q <= '0;
    else          checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb/tb_dmem_copy_engine.sv - scoreboard bench for dmem_copy_engine; checksum cases when DMEM_COPY_CHECKSUM_EN is defined
module tb_dmem_copy_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [31:0] src_addr, dst_addr;
  logic [5:0]  length;
  logic        busy, done, mem_write;
  logic [5:0]  words_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clock = ~clock;

  dmem_copy_engine dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  logic [31:0] mem [0:31];
  assign mem_rdata = mem[mem_addr[4:0]];

  always @(posedge clock) begin
    if (mem_write === 1'b1) mem[mem_addr[4:0]] = mem_wdata;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_fails = 0;
  int write_events = 0;
  int done_events = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done === 1'b1) done_events++;
    if (mem_write === 1'b1) begin
      wr_t e;
      write_events++;
      check("scoreboard_has_entry", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_addr", 64'(mem_addr), 64'(e.addr));
        check("write_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic push_copy(input int src, input int dst, input int len, input int nw);
    bit desc;
    int k;
    wr_t e;
    desc = (dst > src) && (dst < src + len);
    for (int i = 0; i < nw; i++) begin
      k = desc ? (len - 1 - i) : i;
      e.addr = 32'(dst + k);
      e.data = mem[(src + k) % 32];
      exp_q.push_back(e);
    end
  endtask

  task automatic start_copy(input int src, input int dst, input int len, input int nw, input logic abrt);
    @(negedge clock);
    src_addr = 32'(src);
    dst_addr = 32'(dst);
    length   = 6'(len);
    start    = 1'b1;
    abort    = abrt;
    push_copy(src, dst, len, nw);
    @(posedge clock);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (done !== 1'b1 && cyc < 300);
  endtask

  int  cyc;
  int  wr_before, done_before;
  bit  found;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hEE00_0000 + 32'(i);
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_words_done", 64'(words_done), 64'd0);
    reset_n = 1'b1;

    // Case 1: plain ascending copy, start with abort held high in IDLE
    mem[0] = 32'hA0A0_0001; mem[1] = 32'hB0B0_0002;
    mem[2] = 32'hC0C0_0003; mem[3] = 32'hD0D0_0004;
    start_copy(0, 8, 4, 4, 1'b1);
    wait_done(cyc);
    check("c1_done_cycle", 64'(cyc), 64'd9);
    check("c1_words_done", 64'(words_done), 64'd4);
    check("c1_busy_in_done", 64'(busy), 64'd0);
    check("c1_mem8", 64'(mem[8]), 64'hA0A0_0001);
    check("c1_mem11", 64'(mem[11]), 64'hD0D0_0004);
    check("c1_mem12_untouched", 64'(mem[12]), 64'hEE00_000C);

    // Case 2: overlapping, destination above source -> descending
    @(negedge clock);
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
    start_copy(0, 2, 4, 4, 1'b0);
    wait_done(cyc);
    check("c2_done_cycle", 64'(cyc), 64'd9);
    for (int i = 0; i < 4; i++) check("c2_mem_dst", 64'(mem[2 + i]), 64'(i + 1));

    // Case 3: zero length
    wr_before = write_events;
    start_copy(5, 9, 0, 0, 1'b0);
    wait_done(cyc);
    check("c3_done_cycle", 64'(cyc), 64'd1);
    check("c3_words_done", 64'(words_done), 64'd0);
    check("c3_no_writes", 64'(write_events), 64'(wr_before));

    // Case 4: abort during third WRITE
    @(negedge clock);
    for (int i = 16; i < 22; i++) mem[i] = 32'h5A5A_0000 + 32'(i);
    done_before = done_events;
    start_copy(0, 16, 6, 3, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (mem_write === 1'b1 && mem_addr == 32'd18) found = 1'b1;
    end
    check("c4_third_write_seen", 64'(found), 64'd1);
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    repeat (4) @(negedge clock);
    check("c4_words_done", 64'(words_done), 64'd3);
    check("c4_busy", 64'(busy), 64'd0);
    check("c4_no_done", 64'(done_events), 64'(done_before));
    check("c4_mem18", 64'(mem[18]), 64'(mem[2]));
    check("c4_mem19_untouched", 64'(mem[19]), 64'h5A5A_0013);

    // Case 5a: start pulses while busy are ignored
    start_copy(4, 20, 3, 3, 1'b0);
    src_addr = 32'd0; dst_addr = 32'd24; length = 6'd2; start = 1'b1;
    wait_done(cyc);
    start = 1'b0;
    check("c5_done_cycle", 64'(cyc), 64'd7);
    check("c5_words_done", 64'(words_done), 64'd3);
    check("c5_mem24_untouched", 64'(mem[24]), 64'hEE00_0018);

    // Case 5b: reset during the second WRITE
    start_copy(0, 28, 3, 2, 1'b0);
    found = 1'b0;
    for (int i = 0, n = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (mem_write === 1'b1) begin
        n++;
        if (n == 2) found = 1'b1;
      end
    end
    check("c5_second_write_seen", 64'(found), 64'd1);
    check("c5_words_before_rst", 64'(words_done), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("c5_rst_mem_write", 64'(mem_write), 64'd0);
    check("c5_rst_busy", 64'(busy), 64'd0);
    check("c5_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("c5_rst_words_done", 64'(words_done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("c5_idle_after_rst", 64'(busy), 64'd0);
    check("c5_mem29_untouched", 64'(mem[29]), 64'hEE00_001D);

`ifdef DMEM_COPY_CHECKSUM_EN
    // Case 6: checksum accumulation and wrap
    @(negedge clock);
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
    start_copy(0, 12, 3, 3, 1'b0);
    wait_done(cyc);
    check("c6_checksum_sum", 64'(checksum), 64'd6);
    @(negedge clock);
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'd2;
    start_copy(0, 12, 2, 2, 1'b0);
    wait_done(cyc);
    check("c6_checksum_wrap", 64'(checksum), 64'd1);
`endif

    repeat (2) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
